// File: rtl/i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_pkg                                                |
// | Description : Shared types, slot encodings and word alignment helper |
// |               for the I2S capture stage.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package i2s_pkg;

   // Capture FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } i2s_state_e;

   // Word-select level of each slot
   localparam logic SLOT_LEFT  = 1'b0;
   localparam logic SLOT_RIGHT = 1'b1;

   // Left-justify a bitsize-wide word in 32 bits, then keep the top
   // datalen bits: truncates LSBs when narrower, zero-pads when wider.
   function automatic logic [31:0] align_word(input logic [31:0] word,
                                              input int          bitsize,
                                              input int          datalen);
      logic [31:0] msb_aligned;
      msb_aligned = word << (32 - bitsize);
      return msb_aligned >> (32 - datalen);
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_if                                                 |
// | Description : Serial I2S input plus parallel stereo sample bus.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface i2s_if #(
   parameter int DATALEN = 16
);
   logic               lrclk;
   logic               sdata;
   logic [DATALEN-1:0] left_out;
   logic [DATALEN-1:0] right_out;
   logic               sample_valid;
   logic               frame_err;
   logic               locked;

   // Codec side: drives the serial stream, observes captured samples
   modport master (
      output lrclk, sdata,
      input  left_out, right_out, sample_valid, frame_err, locked
   );

   // Receiver side
   modport slave (
      input  lrclk, sdata,
      output left_out, right_out, sample_valid, frame_err, locked
   );
endinterface
`default_nettype wire

// File: rtl/i2s_slot_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_slot_shifter                                       |
// | Description : MSB-first shift register and bit counter for one slot. |
// |               word_o/done_o include the bit sampled this cycle so    |
// |               the slot can be committed on its final shift edge.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2s_slot_shifter #(
   parameter int BITSIZE = 24
) (
   input  logic               bclk,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               shift_en_i,
   input  logic               sdata_i,
   output logic [BITSIZE-1:0] word_o,
   output logic               done_o
);
   localparam int CW = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;

   logic [BITSIZE-1:0] sreg_q;
   logic [BITSIZE-1:0] sreg_d;
   logic [CW-1:0]      bit_cnt_q;

   assign sreg_d = (sreg_q << 1) | BITSIZE'(sdata_i);
   assign word_o = sreg_d;
   assign done_o = shift_en_i && (bit_cnt_q == CW'(BITSIZE - 1));

   // Shift one bit per enabled cycle; clear restarts the slot count
   always_ff @(posedge bclk or posedge reset) begin
      if (reset) begin
         sreg_q    <= '0;
         bit_cnt_q <= '0;
      end else if (clear_i) begin
         sreg_q    <= '0;
         bit_cnt_q <= '0;
      end else if (shift_en_i) begin
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_q + CW'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_receiver                                           |
// | Description : I2S capture stage. Tracks word select, deserializes    |
// |               each slot and presents complete stereo frames.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2s_receiver #(
   parameter int BITSIZE = 24,
   parameter int DATALEN = 16
) (
   input  logic  bclk,
   input  logic  reset,
   i2s_if.slave  bus
);
   import i2s_pkg::*;

   i2s_state_e         state_q;
   logic               lr_q;
   logic               slot_q;
   logic               left_ok_q;
   logic [DATALEN-1:0] left_hold_q;

   logic               w_edge;
   logic               w_fall;
   logic               w_clear;
   logic               w_shift;
   logic               w_done;
   logic [BITSIZE-1:0] w_word;
   logic [DATALEN-1:0] w_aligned;

   assign w_edge    = (bus.lrclk != lr_q);
   assign w_fall    = lr_q & ~bus.lrclk;
   assign w_clear   = (state_q == SKIP);
   assign w_shift   = (state_q == SHIFT);
   assign w_aligned = DATALEN'(align_word(32'(w_word), BITSIZE, DATALEN));

   i2s_slot_shifter #(
      .BITSIZE (BITSIZE)
   ) u_shifter (
      .bclk       (bclk),
      .reset      (reset),
      .clear_i    (w_clear),
      .shift_en_i (w_shift),
      .sdata_i    (bus.sdata),
      .word_o     (w_word),
      .done_o     (w_done)
   );

   // Previous word-select level for edge detection
   always_ff @(posedge bclk or posedge reset) begin
      if (reset) begin
         lr_q <= 1'b0;
      end else begin
         lr_q <= bus.lrclk;
      end
   end

   // Slot tracking FSM with registered frame outputs and pulses
   always_ff @(posedge bclk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         slot_q           <= SLOT_LEFT;
         left_ok_q        <= 1'b0;
         left_hold_q      <= '0;
         bus.left_out     <= '0;
         bus.right_out    <= '0;
         bus.sample_valid <= 1'b0;
         bus.frame_err    <= 1'b0;
         bus.locked       <= 1'b0;
      end else begin
         bus.sample_valid <= 1'b0;
         bus.frame_err    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (w_fall) begin
                  state_q    <= SKIP;
                  bus.locked <= 1'b1;
               end
            end
            SKIP: begin
               slot_q  <= lr_q;
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (w_done) begin
                  // A coincident edge still commits: the bit on the edge
                  // cycle is this slot's LSB.
                  if (slot_q == SLOT_LEFT) begin
                     left_hold_q <= w_aligned;
                     left_ok_q   <= 1'b1;
                  end else if (slot_q == SLOT_RIGHT && left_ok_q) begin
                     bus.left_out     <= left_hold_q;
                     bus.right_out    <= w_aligned;
                     bus.sample_valid <= 1'b1;
                     left_ok_q        <= 1'b0;
                  end
                  state_q <= w_edge ? SKIP : HOLD;
               end else if (w_edge) begin
                  // Short slot: drop the partial frame, resync on new slot
                  bus.frame_err <= 1'b1;
                  left_ok_q     <= 1'b0;
                  state_q       <= SKIP;
               end
            end
            HOLD: begin
               if (w_edge) begin
                  state_q <= SKIP;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_i2s_receiver                                        |
// | Description : Directed-stream bench for i2s_receiver with DATALEN 16 |
// |               and 32 instances sharing one serial stream.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_i2s_receiver;
   localparam int B      = 24;
   localparam int MAXC   = 4096;
   localparam int NOLOCK = 32'h7fffffff;

   logic bclk  = 1'b0;
   logic reset = 1'b1;
   logic lrclk = 1'b0;
   logic sdata = 1'b0;

   i2s_if #(.DATALEN(16)) bus16 ();
   i2s_if #(.DATALEN(32)) bus32 ();

   assign bus16.lrclk = lrclk;
   assign bus16.sdata = sdata;
   assign bus32.lrclk = lrclk;
   assign bus32.sdata = sdata;

   i2s_receiver #(.BITSIZE(B), .DATALEN(16)) dut16 (
      .bclk  (bclk),
      .reset (reset),
      .bus   (bus16)
   );

   i2s_receiver #(.BITSIZE(B), .DATALEN(32)) dut32 (
      .bclk  (bclk),
      .reset (reset),
      .bus   (bus32)
   );

   always #5 bclk = ~bclk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int sv_seen  = 0;
   int fe_seen  = 0;

   // Slot-level model: expected events per posedge index
   bit          exp_sv [MAXC];
   bit          exp_fe [MAXC];
   logic [31:0] exp_lw [MAXC];
   logic [31:0] exp_rw [MAXC];
   int          lock_from   = NOLOCK;
   bit          m_left_ok   = 1'b0;
   logic [31:0] m_left_word = '0;
   logic        m_lr_prev   = 1'b0;
   bit          pend_short  = 1'b0;
   logic        carry_bit   = 1'b0;
   logic [15:0] m16_l = '0, m16_r = '0;
   logic [31:0] m32_l = '0, m32_r = '0;

   function automatic logic [15:0] align16(input logic [31:0] w);
      return 16'(w >> (B - 16));
   endfunction

   function automatic logic [31:0] align32(input logic [31:0] w);
      return w << (32 - B);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, 1 time unit after each posedge
   initial begin
      bit esv, efe, elk;
      forever begin
         @(posedge bclk);
         cyc = cyc + 1;
         #1;
         if (cyc < MAXC) begin
            esv = !reset && exp_sv[cyc];
            efe = !reset && exp_fe[cyc];
            elk = !reset && (cyc >= lock_from);
            if (reset) begin
               m16_l = '0; m16_r = '0; m32_l = '0; m32_r = '0;
            end else if (esv) begin
               m16_l = align16(exp_lw[cyc]); m16_r = align16(exp_rw[cyc]);
               m32_l = align32(exp_lw[cyc]); m32_r = align32(exp_rw[cyc]);
            end
            if (bus16.sample_valid) sv_seen++;
            if (bus16.frame_err)    fe_seen++;
            chk("d16.sample_valid", bus16.sample_valid, esv);
            chk("d16.frame_err",    bus16.frame_err,    efe);
            chk("d16.locked",       bus16.locked,       elk);
            chk("d16.left_out",     bus16.left_out,     m16_l);
            chk("d16.right_out",    bus16.right_out,    m16_r);
            chk("d32.sample_valid", bus32.sample_valid, esv);
            chk("d32.frame_err",    bus32.frame_err,    efe);
            chk("d32.locked",       bus32.locked,       elk);
            chk("d32.left_out",     bus32.left_out,     m32_l);
            chk("d32.right_out",    bus32.right_out,    m32_r);
         end
      end
   end

   // Drive one lrclk slot of len bclk; data bits sampled at slot cycles 2..B+1
   task automatic send_slot(input logic lr, input int len, input logic [31:0] data);
      int p;
      for (int k = 0; k < len; k++) begin
         @(negedge bclk);
         if (k == 0) begin
            p = cyc + 1;
            if (lr !== m_lr_prev) begin
               if (pend_short) begin
                  exp_fe[p] = 1'b1;
                  m_left_ok = 1'b0;
               end
               pend_short = 1'b0;
               if (lock_from == NOLOCK && m_lr_prev == 1'b1 && lr == 1'b0)
                  lock_from = p;
               if (lock_from != NOLOCK) begin
                  if (len >= B + 1) begin
                     if (lr == 1'b0) begin
                        m_left_ok   = 1'b1;
                        m_left_word = data;
                     end else if (m_left_ok && (p + 1 + B) < MAXC) begin
                        exp_sv[p + 1 + B] = 1'b1;
                        exp_lw[p + 1 + B] = m_left_word;
                        exp_rw[p + 1 + B] = data;
                        m_left_ok = 1'b0;
                     end
                  end else begin
                     pend_short = 1'b1;
                  end
               end
            end
            m_lr_prev = lr;
         end
         lrclk = lr;
         if (k == 0)                    sdata = carry_bit;
         else if (k >= 2 && k <= B + 1) sdata = data[B + 1 - k];
         else                           sdata = 1'b0;
      end
      carry_bit = (len == B + 1) ? data[0] : 1'b0;
   endtask

   // Assert reset asynchronously, check outputs clear at once, hold n cycles
   task automatic do_reset(input int n, input logic lr);
      @(negedge bclk);
      reset = 1'b1;
      lrclk = lr;
      sdata = 1'b0;
      carry_bit = 1'b0;
      #1;
      chk("rst.d16.left_out",     bus16.left_out,     32'h0);
      chk("rst.d16.right_out",    bus16.right_out,    32'h0);
      chk("rst.d16.sample_valid", bus16.sample_valid, 32'h0);
      chk("rst.d16.frame_err",    bus16.frame_err,    32'h0);
      chk("rst.d16.locked",       bus16.locked,       32'h0);
      chk("rst.d32.left_out",     bus32.left_out,     32'h0);
      chk("rst.d32.right_out",    bus32.right_out,    32'h0);
      lock_from  = NOLOCK;
      m_left_ok  = 1'b0;
      pend_short = 1'b0;
      m_lr_prev  = 1'b0;
      for (int c = cyc + 1; c < MAXC; c++) begin
         exp_sv[c] = 1'b0;
         exp_fe[c] = 1'b0;
      end
      repeat (n) @(negedge bclk);
      reset = 1'b0;
   endtask

   task automatic chk_outs(input string tag, input logic [15:0] l16, input logic [15:0] r16,
                           input logic [31:0] l32, input logic [31:0] r32);
      chk({tag, ".left16"},  bus16.left_out,  l16);
      chk({tag, ".right16"}, bus16.right_out, r16);
      chk({tag, ".left32"},  bus32.left_out,  l32);
      chk({tag, ".right32"}, bus32.right_out, r32);
   endtask

   initial begin
      int sv0, fe0;
      do_reset(3, 1'b0);

      // Nominal 32-bclk slots
      send_slot(1'b1, 32, 32'h0);
      sv0 = sv_seen; fe0 = fe_seen;
      for (int f = 0; f < 3; f++) begin
         send_slot(1'b0, 32, 32'h123456);
         send_slot(1'b1, 32, 32'hABCDEF);
      end
      chk_outs("nominal", 16'h1234, 16'hABCD, 32'h12345600, 32'hABCDEF00);
      chk("nominal.sv_count", sv_seen - sv0, 3);
      chk("nominal.fe_count", fe_seen - fe0, 0);

      // Short right slot: one error, frame dropped, next frame good
      sv0 = sv_seen; fe0 = fe_seen;
      send_slot(1'b0, 32, 32'h0F1E2D);
      send_slot(1'b1, 20, 32'h3C4B5A);
      send_slot(1'b0, 32, 32'h654321);
      send_slot(1'b1, 32, 32'h0FEDCB);
      chk_outs("short", 16'h6543, 16'h0FED, 32'h65432100, 32'h0FEDCB00);
      chk("short.sv_count", sv_seen - sv0, 1);
      chk("short.fe_count", fe_seen - fe0, 1);

      // Minimum-length slots: commit coincides with the next edge
      sv0 = sv_seen; fe0 = fe_seen;
      for (int f = 0; f < 4; f++) begin
         send_slot(1'b0, 25, 32'h800000);
         send_slot(1'b1, 25, 32'h7FFFFF);
      end
      send_slot(1'b0, 32, 32'h000001);
      chk_outs("tight", 16'h8000, 16'h7FFF, 32'h80000000, 32'h7FFFFF00);
      chk("tight.sv_count", sv_seen - sv0, 4);
      chk("tight.fe_count", fe_seen - fe0, 0);

      // Reset inside a right slot, released while lrclk stays high
      send_slot(1'b1, 10, 32'h111111);
      do_reset(3, 1'b1);
      sv0 = sv_seen;
      send_slot(1'b1, 20, 32'h0);
      chk("relock.locked_before_fall", bus16.locked, 32'h0);
      send_slot(1'b0, 32, 32'h13579B);
      send_slot(1'b1, 32, 32'h2468AC);
      chk_outs("relock", 16'h1357, 16'h2468, 32'h13579B00, 32'h2468AC00);
      chk("relock.sv_count", sv_seen - sv0, 1);

      // Reset during SHIFT of a left slot, then recapture
      send_slot(1'b0, 32, 32'hAAAAAA);
      send_slot(1'b1, 32, 32'h555555);
      chk_outs("pre_rst", 16'hAAAA, 16'h5555, 32'hAAAAAA00, 32'h55555500);
      send_slot(1'b0, 12, 32'h777777);
      do_reset(2, 1'b0);
      sv0 = sv_seen;
      send_slot(1'b0, 10, 32'h0);
      send_slot(1'b1, 32, 32'h0);
      chk("post_rst.no_stale_sv", sv_seen - sv0, 0);
      send_slot(1'b0, 32, 32'h0ABCDE);
      send_slot(1'b1, 32, 32'h0F0F0F);
      chk_outs("post_rst", 16'h0ABC, 16'h0F0F, 32'h0ABCDE00, 32'h0F0F0F00);
      send_slot(1'b0, 8, 32'h0);

      repeat (2) @(negedge bclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
